vga_sprite_engine: RTL and testbench
====================================

Name: vga_sprite_engine

Overview:
- Parametrised VGA timing generator plus N-object rectangle renderer, replacing the fixed 640x480 ball/paddle display block.
- Sits between game logic and the VGA pins, clocked by the pixel clock.
- Object positions are shadow-latched once per frame, so a frame never tears.
- Outputs are fully registered with a fixed pipeline latency, and sync signals are aligned to colour.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 29, vertical back porch (lines)
NUM_OBJ, 4, number of rectangular objects (1..16)
CW, 10, coordinate width (must hold H_TOTAL-1 and V_TOTAL-1)

Ports:
dclk  in  1  pixel clock
clr_n  in  1  asynchronous active-low reset
obj_x  in  NUM_OBJ*CW  object centre X, active-area pixels; object i at [i*CW +: CW]
obj_y  in  NUM_OBJ*CW  object centre Y, active-area lines
obj_hw  in  NUM_OBJ*CW  half-width; object spans x-hw..x+hw inclusive
obj_hh  in  NUM_OBJ*CW  half-height
obj_rgb  in  NUM_OBJ*8  object colour, {r[2:0],g[2:0],b[1:0]}
obj_en  in  NUM_OBJ  object enable
bg_rgb  in  8  background colour inside the active area
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
red  out  3  red
green  out  3  green
blue  out  2  blue
active  out  1  high while output pixel is visible
pix_x  out  CW  active-area X of the output pixel (0 when !active)
pix_y  out  CW  active-area Y of the output pixel (0 when !active)
frame_start  out  1  one-cycle pulse on the first visible pixel of each frame

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL similarly. Defaults give 800x521.
- Counter hc runs 0..H_TOTAL-1; at wrap, vc increments 0..V_TOTAL-1 and wraps.
- Line order: sync, back porch, active, front porch.
  - hsync_raw = hc < H_SYNC.
  - Visible when hc in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vc in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - px = hc-(H_SYNC+H_BP); py = vc-(V_SYNC+V_BP).
- Shadow registers: obj_* inputs and bg_rgb are latched on the last cycle of the last visible line (hc = H_TOTAL-1, vc = V_SYNC+V_BP+V_ACTIVE-1). Input changes at any other time do not affect the current frame.
- Pipeline, latency 2 cycles from counter to pins:
  - S0: counters.
  - S1: per-object hit vector registered, plus px/py, visible, syncs.
  - S2: colour mux registered with delayed syncs, active, pix_x/y and frame_start. All outputs change on the same edge.
- Hit test (per object):
  - Condition: en && px+hw >= x && px <= x+hw && py+hh >= y && py <= y+hh.
  - Computed unsigned at CW+1 bits, so objects partly off the left/top/right/bottom edge clip correctly with no wrap artefacts.
  - hw = 0 gives a 1-pixel-wide object.
- Priority: lowest index hit wins. With no hit, output bg_rgb. When not visible, output RGB = 0 regardless of bg_rgb.
- frame_start: asserted in S2 for the pixel px=0, py=0 only.
- Reset (clr_n low, asynchronous):
  - hc = vc = 0.
  - All shadow registers = 0, so all objects are disabled and bg is black.
  - Pipeline outputs: hsync = 1, vsync = 1, red/green/blue = 0, active = 0, pix_x = pix_y = 0, frame_start = 0.
- Reset deassertion: counting resumes from hc = 0, vc = 0. The first frame after reset shows bg = 0 with no objects. Inputs are picked up at the first shadow-latch point.
- Reset mid-frame: immediate return to the reset state. No partial-frame recovery.

Decomposition:
- Package vga_pkg holds:
  - default timing constants for 640x480@60;
  - RGB332 field widths (R_W = 3, G_W = 3, B_W = 2);
  - a function computing H_TOTAL/V_TOTAL from the timing parameters.
- Sub-module vga_timing: hc/vc counters, raw syncs, visible flag, px/py and the frame-end strobe.
- Top level holds the shadow registers, hit test, priority mux and output pipeline.

Test Plan:
- Defaults, no objects, bg_rgb=8'hFF:
  - hsync low for exactly 96 of every 800 clocks; vsync low for 2 of 521 lines.
  - RGB=FF exactly 640x480 times per frame, 0 elsewhere.
- Object 0 at x=100, y=50, hw=8, hh=8, rgb=8'h1F, enabled: RGB=1F for px 92..108 and py 42..58 (17x17 = 289 pixels); bg elsewhere.
- Objects 0 and 1 overlapping at the same position, rgb 8'hE3 and 8'h1C: overlap shows E3. Disable object 0 mid-frame: no change until the next frame; the following frame shows 1C.
- Object at x=3, y=2, hw=8, hh=8 and object at x=636, hw=8: left block covers px 0..11, py 0..10; right block covers px 628..639. No pixels appear on the opposite edge.
- Assert clr_n=0 mid-line:
  - Outputs immediately hsync=1, vsync=1, RGB=0, active=0.
  - After release, the first frame_start comes exactly (V_SYNC+V_BP)*800+(H_SYNC+H_BP)+2 = 24946 clocks later.
- Non-default parameters H_ACTIVE=320, H_FP=8, H_SYNC=48, H_BP=24, V_ACTIVE=240, V_FP=5, V_SYNC=2, V_BP=14: line period 400, frame 261 lines, 320x240 active pixels, frame_start once per frame.

Source files
------------

// File: rtl/vga_pkg.sv
// VGA timing defaults for 640x480@60, RGB332 field layout and a helper
// that derives a total line/frame period from its four timing segments.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 29;

  localparam int unsigned R_W   = 3;
  localparam int unsigned G_W   = 3;
  localparam int unsigned B_W   = 2;
  localparam int unsigned RGB_W = R_W + G_W + B_W;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb_t;

  function automatic int unsigned seg_total(input int unsigned sync, input int unsigned bp,
                                            input int unsigned act, input int unsigned fp);
    return sync + bp + act + fp;
  endfunction

endpackage

// File: rtl/vga_sprite_engine_if.sv
// Object description bus from game logic into the sprite engine.
interface vga_sprite_engine_if
  import vga_pkg::*;
#(
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned CW      = 10
);
  logic [NUM_OBJ*CW-1:0]    obj_x;
  logic [NUM_OBJ*CW-1:0]    obj_y;
  logic [NUM_OBJ*CW-1:0]    obj_hw;
  logic [NUM_OBJ*CW-1:0]    obj_hh;
  logic [NUM_OBJ*RGB_W-1:0] obj_rgb;
  logic [NUM_OBJ-1:0]       obj_en;
  logic [RGB_W-1:0]         bg_rgb;

  modport master (output obj_x, obj_y, obj_hw, obj_hh, obj_rgb, obj_en, bg_rgb);
  modport slave  (input  obj_x, obj_y, obj_hw, obj_hh, obj_rgb, obj_en, bg_rgb);
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters with combinational sync, visibility,
// active-area coordinates and the once-per-frame shadow latch strobe.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          hsync_c,
  output logic          vsync_c,
  output logic          visible_c,
  output logic [CW-1:0] px_c,
  output logic [CW-1:0] py_c,
  output logic          first_c,
  output logic          latch_c
);
  localparam int unsigned H_TOTAL = seg_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int unsigned V_TOTAL = seg_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned V_END   = V_START + V_ACTIVE;

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic          h_last;
  logic          v_last;

  assign h_last = (hc == CW'(H_TOTAL - 1));
  assign v_last = (vc == CW'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= h_last ? '0 : hc + CW'(1);
      if (h_last) vc <= v_last ? '0 : vc + CW'(1);
    end
  end

  assign hsync_c   = (hc < CW'(H_SYNC));
  assign vsync_c   = (vc < CW'(V_SYNC));
  assign visible_c = (hc >= CW'(H_START)) && (hc < CW'(H_END)) &&
                     (vc >= CW'(V_START)) && (vc < CW'(V_END));
  assign px_c      = hc - CW'(H_START);
  assign py_c      = vc - CW'(V_START);
  assign first_c   = visible_c && (px_c == '0) && (py_c == '0);
  // Last clock of the last visible line: safe point to take a new object set.
  assign latch_c   = h_last && (vc == CW'(V_END - 1));

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA timing plus NUM_OBJ-rectangle renderer with per-frame shadowed object
// state and a two-stage registered output pipeline (syncs aligned to colour).
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned NUM_OBJ  = 4,
  parameter int unsigned CW       = 10
) (
  input  logic               dclk,
  input  logic               clr_n,
  vga_sprite_engine_if.slave objs,
  output logic               hsync,
  output logic               vsync,
  output logic [R_W-1:0]     red,
  output logic [G_W-1:0]     green,
  output logic [B_W-1:0]     blue,
  output logic               active,
  output logic [CW-1:0]      pix_x,
  output logic [CW-1:0]      pix_y,
  output logic               frame_start
);
  logic          hsync_c, vsync_c, visible_c, first_c, latch_c;
  logic [CW-1:0] px_c, py_c;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CW(CW)
  ) u_timing (
    .clk(dclk), .rst_n(clr_n),
    .hsync_c(hsync_c), .vsync_c(vsync_c), .visible_c(visible_c),
    .px_c(px_c), .py_c(py_c), .first_c(first_c), .latch_c(latch_c)
  );

  logic [CW-1:0]      sh_x  [NUM_OBJ];
  logic [CW-1:0]      sh_y  [NUM_OBJ];
  logic [CW-1:0]      sh_hw [NUM_OBJ];
  logic [CW-1:0]      sh_hh [NUM_OBJ];
  rgb_t               sh_rgb[NUM_OBJ];
  logic [NUM_OBJ-1:0] sh_en;
  rgb_t               sh_bg;

  // Shadow copy of the object set; reset leaves everything disabled on black.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < int'(NUM_OBJ); i++) begin
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        sh_hw[i]  <= '0;
        sh_hh[i]  <= '0;
        sh_rgb[i] <= '0;
      end
      sh_en <= '0;
      sh_bg <= '0;
    end else if (latch_c) begin
      for (int i = 0; i < int'(NUM_OBJ); i++) begin
        sh_x[i]   <= objs.obj_x[i*CW +: CW];
        sh_y[i]   <= objs.obj_y[i*CW +: CW];
        sh_hw[i]  <= objs.obj_hw[i*CW +: CW];
        sh_hh[i]  <= objs.obj_hh[i*CW +: CW];
        sh_rgb[i] <= objs.obj_rgb[i*RGB_W +: RGB_W];
      end
      sh_en <= objs.obj_en;
      sh_bg <= objs.bg_rgb;
    end
  end

  logic [CW:0]        px_w, py_w;
  logic [NUM_OBJ-1:0] hit_c;

  assign px_w = {1'b0, px_c};
  assign py_w = {1'b0, py_c};

  // One extra bit keeps x+hw and px+hw from wrapping at the screen edges.
  for (genvar i = 0; i < int'(NUM_OBJ); i++) begin : g_hit
    logic [CW:0] x_w, y_w, hw_w, hh_w;
    assign x_w  = {1'b0, sh_x[i]};
    assign y_w  = {1'b0, sh_y[i]};
    assign hw_w = {1'b0, sh_hw[i]};
    assign hh_w = {1'b0, sh_hh[i]};
    assign hit_c[i] = sh_en[i] &&
                      (px_w + hw_w >= x_w) && (px_w <= x_w + hw_w) &&
                      (py_w + hh_w >= y_w) && (py_w <= y_w + hh_w);
  end

  logic [NUM_OBJ-1:0] hit_s1;
  logic [CW-1:0]      px_s1, py_s1;
  logic               vis_s1, hs_n_s1, vs_n_s1, first_s1;

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hit_s1   <= '0;
      px_s1    <= '0;
      py_s1    <= '0;
      vis_s1   <= 1'b0;
      hs_n_s1  <= 1'b1;
      vs_n_s1  <= 1'b1;
      first_s1 <= 1'b0;
    end else begin
      hit_s1   <= hit_c;
      px_s1    <= px_c;
      py_s1    <= py_c;
      vis_s1   <= visible_c;
      hs_n_s1  <= ~hsync_c;
      vs_n_s1  <= ~vsync_c;
      first_s1 <= first_c;
    end
  end

  rgb_t pix_c;

  // Lowest-index hit wins; blanking forces black regardless of background.
  always_comb begin
    pix_c = sh_bg;
    for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
      if (hit_s1[i]) pix_c = sh_rgb[i];
    end
    if (!vis_s1) pix_c = '0;
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      active      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_n_s1;
      vsync       <= vs_n_s1;
      red         <= pix_c.r;
      green       <= pix_c.g;
      blue        <= pix_c.b;
      active      <= vis_s1;
      pix_x       <= vis_s1 ? px_s1 : '0;
      pix_y       <= vis_s1 ? py_s1 : '0;
      frame_start <= first_s1;
    end
  end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine: default 640x480 timing instance plus a small
// 40x30 timing instance, checked every cycle against a frame-level model.
module tb_vga_sprite_engine;

  localparam int NO = 4;
  localparam int CW = 10;

  localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVA = 480, AVF = 10, AVS = 2,  AVB = 29;
  localparam int AHT = 800, AVT = 521, AFR = AHT * AVT;
  localparam int A_LATCH = (AVS + AVB + AVA - 1) * AHT + AHT - 1;

  localparam int BHA = 40, BHF = 4, BHS = 6, BHB = 6;
  localparam int BVA = 30, BVF = 2, BVS = 2, BVB = 3;
  localparam int BHT = 56, BVT = 37, BFR = BHT * BVT;
  localparam int B_LATCH = (BVS + BVB + BVA - 1) * BHT + BHT - 1;

  typedef struct packed {
    int         x;
    int         y;
    int         hw;
    int         hh;
    logic [7:0] rgb;
    bit         en;
  } obj_t;

  logic dclk  = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 dclk = ~dclk;

  vga_sprite_engine_if #(.NUM_OBJ(NO), .CW(CW)) ifa ();
  vga_sprite_engine_if #(.NUM_OBJ(NO), .CW(CW)) ifb ();

  logic       hsync_a, vsync_a, active_a, frame_start_a;
  logic [2:0] red_a, green_a;
  logic [1:0] blue_a;
  logic [9:0] pix_x_a, pix_y_a;
  logic       hsync_b, vsync_b, active_b, frame_start_b;
  logic [2:0] red_b, green_b;
  logic [1:0] blue_b;
  logic [9:0] pix_x_b, pix_y_b;

  vga_sprite_engine #(.NUM_OBJ(NO), .CW(CW)) dut_a (
    .dclk(dclk), .clr_n(rst_a), .objs(ifa),
    .hsync(hsync_a), .vsync(vsync_a), .red(red_a), .green(green_a), .blue(blue_a),
    .active(active_a), .pix_x(pix_x_a), .pix_y(pix_y_a), .frame_start(frame_start_a)
  );

  vga_sprite_engine #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .NUM_OBJ(NO), .CW(CW)
  ) dut_b (
    .dclk(dclk), .clr_n(rst_b), .objs(ifb),
    .hsync(hsync_b), .vsync(vsync_b), .red(red_b), .green(green_b), .blue(blue_b),
    .active(active_b), .pix_x(pix_x_b), .pix_y(pix_y_b), .frame_start(frame_start_b)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual={hs,vs,rgb,act,x,y,fs}=%h required=%h", name, $time, act, req);
    end
  endtask

  function automatic obj_t read_obj(input logic [NO*CW-1:0] xs, input logic [NO*CW-1:0] ys,
                                    input logic [NO*CW-1:0] ws, input logic [NO*CW-1:0] hs,
                                    input logic [NO*8-1:0] cs, input logic [NO-1:0] ens, input int i);
    obj_t o;
    o.x   = int'(xs[i*CW +: CW]);
    o.y   = int'(ys[i*CW +: CW]);
    o.hw  = int'(ws[i*CW +: CW]);
    o.hh  = int'(hs[i*CW +: CW]);
    o.rgb = cs[i*8 +: 8];
    o.en  = ens[i];
    return o;
  endfunction

  // Colour of a visible pixel: first enabled rectangle containing it, else background.
  function automatic logic [7:0] colour(input int px, input int py, input obj_t o [NO], input logic [7:0] bg);
    logic [7:0] c;
    bit found;
    c = bg;
    found = 1'b0;
    for (int i = 0; i < NO; i++) begin
      if (!found && o[i].en && px >= o[i].x - o[i].hw && px <= o[i].x + o[i].hw &&
          py >= o[i].y - o[i].hh && py <= o[i].y + o[i].hh) begin
        c = o[i].rgb;
        found = 1'b1;
      end
    end
    return c;
  endfunction

  // Outputs after e clocks since reset release: pins show scan position e-2.
  function automatic logic [31:0] expect_out(input int e, input int ha, input int hf, input int hs, input int hb,
                                             input int va, input int vf, input int vsn, input int vb,
                                             input obj_t o [NO], input logic [7:0] bg);
    int n, hc, vc, px, py, ht, vt;
    bit vis;
    logic [7:0] c;
    if (e < 2) return {1'b1, 1'b1, 8'h00, 1'b0, 10'd0, 10'd0, 1'b0};
    ht = hs + hb + ha + hf;
    vt = vsn + vb + va + vf;
    n  = e - 2;
    hc = n % ht;
    vc = (n / ht) % vt;
    vis = (hc >= hs + hb) && (hc < hs + hb + ha) && (vc >= vsn + vb) && (vc < vsn + vb + va);
    px = vis ? hc - hs - hb : 0;
    py = vis ? vc - vsn - vb : 0;
    c  = vis ? colour(px, py, o, bg) : 8'h00;
    return {hc >= hs, vc >= vsn, c, vis, 10'(px), 10'(py), vis && px == 0 && py == 0};
  endfunction

  int         e_a, e_b;
  obj_t       snap_a [NO];
  obj_t       snap_b [NO];
  logic [7:0] sbg_a, sbg_b;

  always @(posedge dclk or negedge rst_a) begin
    if (!rst_a) begin
      e_a <= 0;
      sbg_a <= 8'h00;
      for (int i = 0; i < NO; i++) snap_a[i] <= '0;
    end else begin
      if (e_a % AFR == A_LATCH) begin
        sbg_a <= ifa.bg_rgb;
        for (int i = 0; i < NO; i++)
          snap_a[i] <= read_obj(ifa.obj_x, ifa.obj_y, ifa.obj_hw, ifa.obj_hh, ifa.obj_rgb, ifa.obj_en, i);
      end
      e_a <= e_a + 1;
    end
  end

  always @(posedge dclk or negedge rst_b) begin
    if (!rst_b) begin
      e_b <= 0;
      sbg_b <= 8'h00;
      for (int i = 0; i < NO; i++) snap_b[i] <= '0;
    end else begin
      if (e_b % BFR == B_LATCH) begin
        sbg_b <= ifb.bg_rgb;
        for (int i = 0; i < NO; i++)
          snap_b[i] <= read_obj(ifb.obj_x, ifb.obj_y, ifb.obj_hw, ifb.obj_hh, ifb.obj_rgb, ifb.obj_en, i);
      end
      e_b <= e_b + 1;
    end
  end

  always @(negedge dclk) begin
    if (chk_en) begin
      check_vec("pipe_a",
                {hsync_a, vsync_a, red_a, green_a, blue_a, active_a, pix_x_a, pix_y_a, frame_start_a},
                expect_out(e_a, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, snap_a, sbg_a));
      check_vec("pipe_b",
                {hsync_b, vsync_b, red_b, green_b, blue_b, active_b, pix_x_b, pix_y_b, frame_start_b},
                expect_out(e_b, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, snap_b, sbg_b));
    end
  end

  task automatic set_obj_b(input int i, input int x, input int y, input int hw, input int hh,
                           input logic [7:0] rgb, input bit en);
    ifb.obj_x[i*CW +: CW]  = CW'(x);
    ifb.obj_y[i*CW +: CW]  = CW'(y);
    ifb.obj_hw[i*CW +: CW] = CW'(hw);
    ifb.obj_hh[i*CW +: CW] = CW'(hh);
    ifb.obj_rgb[i*8 +: 8]  = rgb;
    ifb.obj_en[i]          = en;
  endtask

  int n_ff, n_e3, n_1c, n_1f, n_03, n_blk, n_act, n_hs, n_vs, n_fs;

  // Tally one full frame period of B starting on its frame_start sample.
  task automatic run_frame_b();
    logic [7:0] c;
    n_ff = 0; n_e3 = 0; n_1c = 0; n_1f = 0; n_03 = 0; n_blk = 0;
    n_act = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    for (int k = 0; k < BFR; k++) begin
      if (k > 0) @(negedge dclk);
      c = {red_b, green_b, blue_b};
      if (active_b) begin
        n_act++;
        case (c)
          8'hFF: n_ff++;
          8'hE3: n_e3++;
          8'h1C: n_1c++;
          8'h1F: n_1f++;
          8'h03: n_03++;
          8'h00: n_blk++;
          default: ;
        endcase
      end
      if (!hsync_b) n_hs++;
      if (!vsync_b) n_vs++;
      if (frame_start_b) n_fs++;
    end
    @(negedge dclk);
  endtask

  int exp_ff  [6] = '{0, 1200, 1151, 1151, 1151, 983};
  int exp_e3  [6] = '{0, 0, 0, 49, 0, 132};
  int exp_1c  [6] = '{0, 0, 0, 0, 49, 84};
  int exp_1f  [6] = '{0, 0, 49, 0, 0, 0};
  int exp_03  [6] = '{0, 0, 0, 0, 0, 1};
  int exp_blk [6] = '{1200, 0, 0, 0, 0, 0};

  initial begin
    int cnt_hs, cnt_vs, lat;
    bit seen;
    ifa.obj_x = '0; ifa.obj_y = '0; ifa.obj_hw = '0; ifa.obj_hh = '0;
    ifa.obj_rgb = '0; ifa.obj_en = '0; ifa.bg_rgb = 8'hFF;
    ifb.obj_x = '0; ifb.obj_y = '0; ifb.obj_hw = '0; ifb.obj_hh = '0;
    ifb.obj_rgb = '0; ifb.obj_en = '0; ifb.bg_rgb = 8'hFF;
    #1 rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge dclk);
    chk_en = 1'b1;
    check_int("reset_hsync", int'(hsync_a), 1);
    check_int("reset_vsync", int'(vsync_a), 1);
    check_int("reset_rgb", int'({red_a, green_a, blue_a}), 0);
    check_int("reset_active", int'(active_a), 0);

    // Release A and measure sync duty over the first 850 pixels.
    #2 rst_a = 1'b1;
    @(negedge dclk);
    cnt_hs = 0;
    cnt_vs = 0;
    for (int k = 0; k < 850; k++) begin
      @(negedge dclk);
      if (k < 800 && !hsync_a) cnt_hs++;
      if (!vsync_a) cnt_vs++;
    end
    check_int("hsync_low_per_line", cnt_hs, 96);
    check_int("vsync_low_first_850", cnt_vs, 850);
    check_int("sync_low_before_reset", int'({hsync_a, vsync_a}), 0);

    // Asynchronous reset in the middle of line 1, inside both sync pulses.
    #2 rst_a = 1'b0;
    #1;
    check_int("midreset_hsync", int'(hsync_a), 1);
    check_int("midreset_vsync", int'(vsync_a), 1);
    check_int("midreset_rgb", int'({red_a, green_a, blue_a}), 0);
    check_int("midreset_active", int'(active_a), 0);
    check_int("midreset_pix", int'({pix_x_a, pix_y_a}), 0);
    repeat (5) @(negedge dclk);
    #2 rst_a = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 30000 && !seen; k++) begin
      @(negedge dclk);
      lat++;
      if (frame_start_a) seen = 1'b1;
    end
    check_int("first_frame_start_latency_a", lat, 24946);
    repeat (1700) @(negedge dclk);

    // Small-timing instance: per-frame pixel statistics across object changes.
    #2 rst_b = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge dclk);
      lat++;
      if (frame_start_b) seen = 1'b1;
    end
    check_int("first_frame_start_latency_b", lat, 294);

    for (int f = 0; f < 6; f++) begin
      case (f)
        1: set_obj_b(0, 10, 8, 3, 3, 8'h1F, 1'b1);
        2: begin
          set_obj_b(0, 10, 8, 3, 3, 8'hE3, 1'b1);
          set_obj_b(1, 10, 8, 3, 3, 8'h1C, 1'b1);
        end
        3: ifb.obj_en[0] = 1'b0;
        4: begin
          set_obj_b(0, 3, 2, 8, 8, 8'hE3, 1'b1);
          set_obj_b(1, 36, 20, 8, 3, 8'h1C, 1'b1);
          set_obj_b(2, 20, 25, 0, 0, 8'h03, 1'b1);
        end
        default: ;
      endcase
      run_frame_b();
      check_int($sformatf("f%0d_ff", f), n_ff, exp_ff[f]);
      check_int($sformatf("f%0d_e3", f), n_e3, exp_e3[f]);
      check_int($sformatf("f%0d_1c", f), n_1c, exp_1c[f]);
      check_int($sformatf("f%0d_1f", f), n_1f, exp_1f[f]);
      check_int($sformatf("f%0d_03", f), n_03, exp_03[f]);
      check_int($sformatf("f%0d_black", f), n_blk, exp_blk[f]);
      check_int($sformatf("f%0d_active", f), n_act, 1200);
      check_int($sformatf("f%0d_hsync_low", f), n_hs, 222);
      check_int($sformatf("f%0d_vsync_low", f), n_vs, 112);
      check_int($sformatf("f%0d_frame_start", f), n_fs, 1);
      check_int($sformatf("f%0d_next_frame_start", f), int'(frame_start_b), 1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
